// File: rtl/bus_multiplexer_pkg.sv
// Shared platform constants, arbitration modes and bus payload types for bus_multiplexer.
package bus_multiplexer_pkg;

  // Platform bus geometry
  localparam int unsigned XLEN        = 32;
  localparam int unsigned BUS_WIDTH   = 32;
  localparam int unsigned BUS_ACC_CNT = 3;
  localparam int unsigned ACC_W       = $clog2(BUS_ACC_CNT);

  // Arbitration modes
  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // One channel's request payload as presented to the slave
  typedef struct packed {
    logic [XLEN-1:0]      addr;
    logic                 w_rb;
    logic [ACC_W-1:0]     acc;
    logic [BUS_WIDTH-1:0] wdata;
  } bus_cmd_t;

  // Index width that never collapses to zero bits
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arb_picker.sv
// Combinational grant picker: first requester found scanning upward from a start index.
module bus_arb_picker
  import bus_multiplexer_pkg::*;
#(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned MODE  = ARB_RR,
  parameter int unsigned IDX_W = idx_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  logic [IDX_W-1:0] base;
  int unsigned      idx;

  // Fixed priority is a round-robin scan that always starts at channel 0
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    base  = (MODE == ARB_FIXED) ? '0 : start;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = (32'(base) + i) % N_CH;
      if (!valid && req[IDX_W'(idx)]) begin
        valid = 1'b1;
        grant = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_multiplexer.sv
// N-channel master-to-single-slave bus multiplexer with arbitration and response watchdog.
module bus_multiplexer
  import bus_multiplexer_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*XLEN-1:0]      m_addr,
  input  logic [N_CH-1:0]           m_w_rb,
  input  logic [N_CH*ACC_W-1:0]     m_acc,
  input  logic [N_CH*BUS_WIDTH-1:0] m_wdata,
  input  logic [N_CH-1:0]           m_req,
  output logic [BUS_WIDTH-1:0]      m_rdata,
  output logic [N_CH-1:0]           m_resp,
  output logic [N_CH-1:0]           m_fault,
  output logic [XLEN-1:0]           s_addr,
  output logic                      s_w_rb,
  output logic [ACC_W-1:0]          s_acc,
  output logic [BUS_WIDTH-1:0]      s_wdata,
  output logic                      s_req,
  input  logic [BUS_WIDTH-1:0]      s_rdata,
  input  logic                      s_resp,
  input  logic                      s_fault
);

  localparam int unsigned      IDX_W    = idx_width(N_CH);
  localparam int unsigned      CNT_W    = idx_width(TIMEOUT);
  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

  bus_cmd_t         cmd [N_CH];
  bus_cmd_t         sel;
  state_t           state, state_next;
  logic [IDX_W-1:0] g, last_g, start, pick;
  logic             pick_valid, grant, timeout_hit;
  logic [CNT_W-1:0] cnt;

  // Unpack the flattened master vectors into per-channel payloads
  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign cmd[k] = {m_addr[k*XLEN +: XLEN], m_w_rb[k],
                     m_acc[k*ACC_W +: ACC_W], m_wdata[k*BUS_WIDTH +: BUS_WIDTH]};
  end

  // Round-robin search begins just after the last granted channel
  assign start = (last_g == IDX_LAST) ? '0 : last_g + 1'b1;

  bus_arb_picker #(
    .N_CH  (N_CH),
    .MODE  (ARB_MODE),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (m_req),
    .start (start),
    .grant (pick),
    .valid (pick_valid)
  );

  // State, grant index and watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      g      <= '0;
      last_g <= IDX_LAST;
      cnt    <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        g      <= pick;
        last_g <= pick;
        cnt    <= '0;
      end else if (state == ST_BUSY) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Next state and combinational slave/master routing
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    timeout_hit = 1'b0;
    sel         = '0;
    s_req       = 1'b0;
    m_resp      = '0;
    m_fault     = '0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant      = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        s_req = 1'b1;
        sel   = cmd[g];
        // A real slave response on the last watchdog cycle wins over the timeout
        timeout_hit = TO_EN && (cnt == CNT_LAST) && !s_resp;
        if (s_resp) m_resp[g] = 1'b1;
        if (s_fault || timeout_hit) m_fault[g] = 1'b1;
        if (s_resp || s_fault || timeout_hit) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign s_addr  = sel.addr;
  assign s_w_rb  = sel.w_rb;
  assign s_acc   = sel.acc;
  assign s_wdata = sel.wdata;
  assign m_rdata = s_rdata;

endmodule

// File: tb/tb_bus_multiplexer.sv
// Directed bench for bus_multiplexer: a 4-channel round-robin instance checked every cycle
// against a transaction-level model, plus a 2-channel fixed-priority instance.
module tb_bus_multiplexer;
  import bus_multiplexer_pkg::*;

  localparam int unsigned A_N  = 4;
  localparam int unsigned A_TO = 8;
  localparam int unsigned B_N  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: 4 channels, round-robin, watchdog 8
  logic [XLEN-1:0]      a_addr  [A_N];
  logic [ACC_W-1:0]     a_acc   [A_N];
  logic [BUS_WIDTH-1:0] a_wdata [A_N];
  logic [A_N-1:0]       a_w_rb, a_req;
  logic [A_N*XLEN-1:0]      a_addr_f;
  logic [A_N*ACC_W-1:0]     a_acc_f;
  logic [A_N*BUS_WIDTH-1:0] a_wdata_f;
  logic [BUS_WIDTH-1:0] a_m_rdata, a_s_wdata, a_s_rdata;
  logic [A_N-1:0]       a_m_resp, a_m_fault;
  logic [XLEN-1:0]      a_s_addr;
  logic [ACC_W-1:0]     a_s_acc;
  logic                 a_s_w_rb, a_s_req, a_s_resp, a_s_fault;
  logic                 a_resp_drv, a_fault_drv, a_auto;

  // Instance B: 2 channels, fixed priority
  logic [XLEN-1:0]      b_addr  [B_N];
  logic [ACC_W-1:0]     b_acc   [B_N];
  logic [BUS_WIDTH-1:0] b_wdata [B_N];
  logic [B_N-1:0]       b_w_rb, b_req;
  logic [B_N*XLEN-1:0]      b_addr_f;
  logic [B_N*ACC_W-1:0]     b_acc_f;
  logic [B_N*BUS_WIDTH-1:0] b_wdata_f;
  logic [BUS_WIDTH-1:0] b_m_rdata, b_s_wdata, b_s_rdata;
  logic [B_N-1:0]       b_m_resp, b_m_fault;
  logic [XLEN-1:0]      b_s_addr;
  logic [ACC_W-1:0]     b_s_acc;
  logic                 b_s_w_rb, b_s_req, b_s_resp, b_s_fault;
  logic                 b_resp_drv, b_auto;

  for (genvar k = 0; k < A_N; k++) begin : g_a_pack
    assign a_addr_f[k*XLEN +: XLEN]            = a_addr[k];
    assign a_acc_f[k*ACC_W +: ACC_W]           = a_acc[k];
    assign a_wdata_f[k*BUS_WIDTH +: BUS_WIDTH] = a_wdata[k];
  end
  for (genvar k = 0; k < B_N; k++) begin : g_b_pack
    assign b_addr_f[k*XLEN +: XLEN]            = b_addr[k];
    assign b_acc_f[k*ACC_W +: ACC_W]           = b_acc[k];
    assign b_wdata_f[k*BUS_WIDTH +: BUS_WIDTH] = b_wdata[k];
  end

  // Slave stubs: directed response, or respond in the first BUSY cycle when auto is set
  assign a_s_resp  = a_resp_drv | (a_auto & a_s_req);
  assign a_s_fault = a_fault_drv;
  assign b_s_resp  = b_resp_drv | (b_auto & b_s_req);
  assign b_s_fault = 1'b0;

  bus_multiplexer #(.N_CH(A_N), .ARB_MODE(1), .TIMEOUT(A_TO)) dut_a (
    .clk(clk), .rst(rst),
    .m_addr(a_addr_f), .m_w_rb(a_w_rb), .m_acc(a_acc_f), .m_wdata(a_wdata_f), .m_req(a_req),
    .m_rdata(a_m_rdata), .m_resp(a_m_resp), .m_fault(a_m_fault),
    .s_addr(a_s_addr), .s_w_rb(a_s_w_rb), .s_acc(a_s_acc), .s_wdata(a_s_wdata), .s_req(a_s_req),
    .s_rdata(a_s_rdata), .s_resp(a_s_resp), .s_fault(a_s_fault)
  );

  bus_multiplexer #(.N_CH(B_N), .ARB_MODE(0), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst),
    .m_addr(b_addr_f), .m_w_rb(b_w_rb), .m_acc(b_acc_f), .m_wdata(b_wdata_f), .m_req(b_req),
    .m_rdata(b_m_rdata), .m_resp(b_m_resp), .m_fault(b_m_fault),
    .s_addr(b_s_addr), .s_w_rb(b_s_w_rb), .s_acc(b_s_acc), .s_wdata(b_s_wdata), .s_req(b_s_req),
    .s_rdata(b_s_rdata), .s_resp(b_s_resp), .s_fault(b_s_fault)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model of instance A: who owns the slave, for how many cycles,
  // and which channel is considered first at the next arbitration.
  bit mb;
  int mo, mnext, mage;
  int m_order[$];
  int d_order[$];
  bit rec_on = 1'b0;

  always @(negedge clk) begin : a_model
    logic [A_N-1:0] er, ef;
    int  s, first;
    bit  found;
    if (rst) begin
      mb = 1'b0; mo = 0; mnext = 0; mage = 0;
    end
    er = '0;
    ef = '0;
    if (mb) begin
      if (a_s_resp) er[mo] = 1'b1;
      if (a_s_fault || (mage == A_TO && !a_s_resp)) ef[mo] = 1'b1;
    end
    chk("a_s_req",   a_s_req,   mb);
    chk("a_s_addr",  a_s_addr,  mb ? a_addr[mo]  : '0);
    chk("a_s_w_rb",  a_s_w_rb,  mb ? a_w_rb[mo]  : 1'b0);
    chk("a_s_acc",   a_s_acc,   mb ? a_acc[mo]   : '0);
    chk("a_s_wdata", a_s_wdata, mb ? a_wdata[mo] : '0);
    chk("a_m_resp",  a_m_resp,  er);
    chk("a_m_fault", a_m_fault, ef);
    chk("a_m_rdata", a_m_rdata, a_s_rdata);
    if (rec_on) begin
      for (int k = 0; k < A_N; k++) if (a_m_resp[k]) d_order.push_back(k);
    end
    if (!rst) begin
      if (mb) begin
        if (a_s_resp || a_s_fault || mage == A_TO) mb = 1'b0;
        else mage++;
      end else begin
        found = 1'b0;
        first = mnext;
        for (int i = 0; i < A_N; i++) begin
          s = (first + i) % A_N;
          if (!found && a_req[s]) begin found = 1'b1; mo = s; end
        end
        if (found) begin
          mb = 1'b1; mage = 1; mnext = (mo + 1) % A_N;
          if (rec_on) m_order.push_back(mo);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin : stim
    int exp_rr[5];
    int guard, busy_cycles, cnt0, cnt1;
    logic [A_N-1:0] fault_seen;
    exp_rr = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    a_req = '0; a_w_rb = '0; a_resp_drv = 0; a_fault_drv = 0; a_auto = 0; a_s_rdata = 32'hCAFE_0001;
    b_req = '0; b_w_rb = '0; b_resp_drv = 0; b_auto = 0; b_s_rdata = '0;
    for (int k = 0; k < A_N; k++) begin
      a_addr[k]  = 32'h1000 + 32'(k) * 32'h10;
      a_acc[k]   = ACC_W'(k % 3);
      a_wdata[k] = 32'hD000_0000 + 32'(k);
      a_w_rb[k]  = k[0];
    end
    for (int k = 0; k < B_N; k++) begin
      b_addr[k] = '0; b_acc[k] = '0; b_wdata[k] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_s_req", a_s_req, 1'b0);
    chk("rst_a_m_resp", a_m_resp, '0);
    chk("rst_b_s_req", b_s_req, 1'b0);
    chk("rst_b_s_addr", b_s_addr, '0);
    step();
    rst = 1'b0;

    // Round-robin fairness with all channels requesting and an immediate slave
    a_auto = 1'b1;
    rec_on = 1'b1;
    a_req  = 4'hF;
    guard  = 0;
    while (d_order.size() < 5 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    step();
    a_req  = '0;
    rec_on = 1'b0;
    chk("rr_count", d_order.size() >= 5, 1'b1);
    chk("rr_model_count", m_order.size() >= 5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i < d_order.size()) chk("rr_dut_order", d_order[i], exp_rr[i]);
      if (i < m_order.size()) chk("rr_model_order", m_order[i], exp_rr[i]);
    end
    step();
    a_auto = 1'b0;

    // A requester that drops before being granted is ignored
    step();
    a_req = 4'b0100;
    step();
    a_req = 4'b0110;
    step();
    a_req = 4'b0100;
    a_resp_drv = 1'b1;
    @(negedge clk);
    chk("drop_resp_ch2", a_m_resp, 4'b0100);
    step();
    a_resp_drv = 1'b0;
    a_req = '0;
    step();
    @(negedge clk);
    chk("drop_no_grant", a_s_req, 1'b0);

    // Watchdog: silent slave, fault in BUSY cycle 8
    step();
    a_req = 4'b1000;
    busy_cycles = 0;
    fault_seen = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_s_req) busy_cycles++;
      if (a_m_fault != 0) begin
        fault_seen = a_m_fault;
        break;
      end
    end
    chk("to_busy_cycles", busy_cycles, 8);
    chk("to_fault", fault_seen, 4'b1000);
    step();
    a_req = '0;
    @(negedge clk);
    chk("to_sreq_fall", a_s_req, 1'b0);
    step();
    a_req = 4'b0010;
    step();
    a_resp_drv = 1'b1;
    @(negedge clk);
    chk("after_to_resp", a_m_resp, 4'b0010);
    chk("after_to_fault", a_m_fault, 4'b0000);
    step();
    a_resp_drv = 1'b0;
    a_req = '0;

    // Slave response and fault together are both forwarded
    step();
    a_req = 4'b1000;
    step();
    a_resp_drv = 1'b1;
    a_fault_drv = 1'b1;
    @(negedge clk);
    chk("both_resp", a_m_resp, 4'b1000);
    chk("both_fault", a_m_fault, 4'b1000);
    step();
    a_resp_drv = 1'b0;
    a_fault_drv = 1'b0;
    a_req = '0;

    // Response on the timeout cycle suppresses the timeout fault
    step();
    a_req = 4'b0001;
    step();
    repeat (7) step();
    a_resp_drv = 1'b1;
    @(negedge clk);
    chk("tocyc_resp", a_m_resp, 4'b0001);
    chk("tocyc_fault", a_m_fault, 4'b0000);
    step();
    a_resp_drv = 1'b0;
    a_req = '0;

    // Reset mid-BUSY abandons the transfer; channel 0 is considered first afterwards
    step();
    a_req = 4'b0100;
    step();
    @(negedge clk);
    chk("pre_rst_sreq", a_s_req, 1'b1);
    chk("pre_rst_addr", a_s_addr, 32'h1020);
    step();
    rst = 1'b1;
    a_req = 4'b1001;
    a_resp_drv = 1'b1;
    @(negedge clk);
    chk("in_rst_sreq", a_s_req, 1'b0);
    chk("in_rst_addr", a_s_addr, 32'h0);
    chk("in_rst_resp", a_m_resp, 4'b0000);
    chk("in_rst_fault", a_m_fault, 4'b0000);
    step();
    rst = 1'b0;
    a_resp_drv = 1'b0;
    step();
    a_resp_drv = 1'b1;
    @(negedge clk);
    chk("post_rst_addr", a_s_addr, 32'h1000);
    chk("post_rst_resp", a_m_resp, 4'b0001);
    step();
    a_resp_drv = 1'b0;
    a_req = '0;

    // Instance B: single read from channel 1
    step();
    b_addr[1] = 32'h40;
    b_w_rb[1] = 1'b0;
    b_acc[1]  = ACC_W'(2);
    b_req     = 2'b10;
    @(negedge clk);
    chk("b_latency_idle", b_s_req, 1'b0);
    step();
    @(negedge clk);
    chk("b_sreq", b_s_req, 1'b1);
    chk("b_saddr", b_s_addr, 32'h40);
    chk("b_sw_rb", b_s_w_rb, 1'b0);
    step();
    b_s_rdata  = 32'hDEAD_BEEF;
    b_resp_drv = 1'b1;
    @(negedge clk);
    chk("b_mresp", b_m_resp, 2'b10);
    chk("b_mrdata", b_m_rdata, 32'hDEAD_BEEF);
    chk("b_mfault", b_m_fault, 2'b00);
    step();
    b_resp_drv = 1'b0;
    b_req = '0;

    // Instance B: fixed priority starves channel 1 while channel 0 holds its request
    b_addr[0] = 32'h100;
    b_auto = 1'b1;
    b_req  = 2'b11;
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b_m_resp[0]) cnt0++;
      if (b_m_resp[1]) cnt1++;
    end
    chk("fp_ch1_starved", cnt1, 0);
    chk("fp_ch0_grants", cnt0, 6);
    step();
    b_req = 2'b10;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("fp_ch1_after_release", b_m_resp, 2'b10);
    step();
    b_req = '0;
    b_auto = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
